mpsoc_wb_arbiter: RTL and testbench
===================================

MPSOC_WB_ARBITER -- requirements
Module: mpsoc_wb_arbiter

Interface
REQ-001 SHALL have parameters, one per line as name, default, meaning:
  - DW, 32, data width.
  - AW, 32, address width.
  - NM, 4, number of masters (1..16).
  - TIMEOUT, 256, stalled-strobe cycles before forced error (>=2).
REQ-002 SHALL have ports, one per line as name, direction, width, meaning (master buses flattened, master i at slice i):
  - wb_clk, in, 1, the block's one clock.
  - wb_rst_n, in, 1, reset, asynchronous, active-low.
  - wbm_adr_i, in, NM*AW, master addresses.
  - wbm_dat_i, in, NM*DW, master write data.
  - wbm_sel_i, in, NM*DW/8, master byte selects.
  - wbm_we_i / wbm_cyc_i / wbm_stb_i, in, NM each, master controls.
  - wbm_cti_i, in, NM*3, master cycle type.
  - wbm_bte_i, in, NM*2, master burst type.
  - wbm_dat_o, out, DW, read data broadcast to all masters.
  - wbm_ack_o / wbm_err_o / wbm_rty_o, out, NM each, per-master responses.
  - wbs_adr_o / wbs_dat_o / wbs_sel_o, out, AW / DW / DW/8, slave request.
  - wbs_we_o / wbs_cyc_o / wbs_stb_o, out, 1 each, slave controls.
  - wbs_cti_o / wbs_bte_o, out, 3 / 2, slave burst info.
  - wbs_dat_i, in, DW, slave read data.
  - wbs_ack_i / wbs_err_i / wbs_rty_i, in, 1 each, slave responses.
  - grant_o, out, NM, one-hot-or-zero current owner.

Function
REQ-003 SHALL implement a two-state FSM: IDLE (grant_o=0) and OWNED (exactly one grant bit set).
REQ-004 In IDLE with any wbm_cyc_i high, SHALL register a grant at the next wb_clk edge (1-cycle arbitration latency) and go to OWNED.
REQ-005 Selection SHALL be round-robin: search starts at index (last_owner+1) mod NM, and first cyc_i high wins.
REQ-006 In OWNED, SHALL hold the grant while the owner's wbm_cyc_i is high, even with stb low or other requests pending (no preemption; covers bursts and RMW).
REQ-007 When the owner's wbm_cyc_i is low at a clock edge, SHALL update last_owner and re-arbitrate at that same edge: the next requester is granted the following cycle, or the FSM returns to IDLE if none.
REQ-008 wbs_adr/dat/sel/we/cti/bte_o SHALL combinationally mux the owner's inputs; all SHALL be 0 in IDLE.
REQ-009 wbs_cyc_o SHALL equal owner cyc_i; wbs_stb_o SHALL equal owner stb_i AND NOT timeout_hit.
REQ-010 wbs_ack_i/err_i/rty_i SHALL route only to the owner's wbm_*_o bit; non-owners SHALL see 0, and pending non-owners SHALL wait with no response.
REQ-011 wbm_dat_o SHALL equal wbs_dat_i at all times.
REQ-012 Watchdog counter, width clog2(TIMEOUT+1):
  - increments each cycle the owner's stb_i is high with no slave response;
  - clears on any response, on stb_i low, or on an ownership change.
REQ-013 When the counter equals TIMEOUT, SHALL assert timeout_hit for that cycle: wbm_err_o to the owner =1, wbs_stb_o =0, slave responses that cycle ignored, counter cleared at the next edge.
REQ-014 A slave response arriving in the same cycle the owner drops cyc_i SHALL still be delivered to that owner.
REQ-015 With NM=1, SHALL degrade to pass-through with 1-cycle grant latency and the watchdog still active.
REQ-016 grant_o SHALL never have more than one bit set.

Reset
REQ-017 wb_rst_n low SHALL asynchronously force IDLE, grant_o=0, counter=0 and last_owner=NM-1 (master 0 wins first), so all wbs_*_o and wbm_*_o outputs read 0.
REQ-018 Reset release SHALL be synchronous to wb_clk; the first grant is possible at the second edge after release.

Verification
REQ-019 Single request: master 1 raises cyc/stb at cycle 0 and the slave acks whenever stb is seen -> grant_o=4'b0010 from cycle 1, wbs_stb_o high in cycle 1, wbm_ack_o=4'b0010 in cycle 1, other acks 0.
REQ-020 Contention: all four masters request from reset, each drops cyc after one acked transfer -> grant order 0,1,2,3, with one grant per 2 cycles.
REQ-021 Burst lock: master 0 runs a 4-beat cti=3'b010 burst while master 2 requests -> grant_o stays 4'b0001 until master 0 cyc drops, then 4'b0100.
REQ-022 Timeout: TIMEOUT=16, slave never responds, master 3 holds stb -> wbm_err_o[3]=1 in exactly the 17th stb cycle, wbs_stb_o=0 in that cycle, no other error bits set.
REQ-023 Reset mid-burst: wb_rst_n low asynchronously between edges -> grant_o and all wbs_*_o are 0 before the next edge; after release, master 0 wins a 0/2 tie.
REQ-024 Error/retry pass-through: slave returns err then rty to master 2 -> wbm_err_o=4'b0100 then wbm_rty_o=4'b0100, and the watchdog counter reads 0 after each.

Source files
------------

// File: rtl/mpsoc_wb_arbiter.sv
// Round-robin Wishbone arbiter: NM masters share one slave port.
// Bus ownership is held for the owner's whole cycle. A stall watchdog ends hung strobes with an error.
module mpsoc_wb_arbiter #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int NM      = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst_n,
  input  logic [NM*AW-1:0]     wbm_adr_i,
  input  logic [NM*DW-1:0]     wbm_dat_i,
  input  logic [NM*DW/8-1:0]   wbm_sel_i,
  input  logic [NM-1:0]        wbm_we_i,
  input  logic [NM-1:0]        wbm_cyc_i,
  input  logic [NM-1:0]        wbm_stb_i,
  input  logic [NM*3-1:0]      wbm_cti_i,
  input  logic [NM*2-1:0]      wbm_bte_i,
  output logic [DW-1:0]        wbm_dat_o,
  output logic [NM-1:0]        wbm_ack_o,
  output logic [NM-1:0]        wbm_err_o,
  output logic [NM-1:0]        wbm_rty_o,
  output logic [AW-1:0]        wbs_adr_o,
  output logic [DW-1:0]        wbs_dat_o,
  output logic [DW/8-1:0]      wbs_sel_o,
  output logic                 wbs_we_o,
  output logic                 wbs_cyc_o,
  output logic                 wbs_stb_o,
  output logic [2:0]           wbs_cti_o,
  output logic [1:0]           wbs_bte_o,
  input  logic [DW-1:0]        wbs_dat_i,
  input  logic                 wbs_ack_i,
  input  logic                 wbs_err_i,
  input  logic                 wbs_rty_i,
  output logic [NM-1:0]        grant_o
);

  localparam int OW = (NM > 1) ? $clog2(NM) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int SW = DW / 8;

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   last_q, last_d;
  logic [CW-1:0]   wdog_q, wdog_d;
  logic            armed_q;

  logic            owned_s, own_cyc_s, own_stb_s, resp_s, timeout_hit_s, found_s;
  logic [NM-1:0]   own_oh_s;
  logic [OW-1:0]   base_s, pick_s;

  assign owned_s       = (state_q == OWNED);
  assign own_cyc_s     = |(own_oh_s & wbm_cyc_i);
  assign own_stb_s     = |(own_oh_s & wbm_stb_i);
  assign resp_s        = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign timeout_hit_s = owned_s & (wdog_q == CW'(TIMEOUT));
  assign found_s       = |wbm_cyc_i;
  assign base_s        = owned_s ? owner_q : last_q;

  // One-hot owner vector; zero while idle.
  always_comb begin
    own_oh_s = '0;
    if (owned_s) begin
      own_oh_s[owner_q] = 1'b1;
    end else begin
      own_oh_s = '0;
    end
  end

  // Round-robin pick: walk backwards so the first requester after base wins.
  always_comb begin
    int idx;
    idx    = 0;
    pick_s = '0;
    for (int k = NM; k >= 1; k--) begin
      idx    = (int'(base_s) + k) % NM;
      pick_s = wbm_cyc_i[idx] ? OW'(idx) : pick_s;
    end
  end

  // Ownership FSM; the owner's cycle end re-arbitrates at the same edge.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (armed_q && found_s) begin
          state_d = OWNED;
          owner_d = pick_s;
        end else begin
          state_d = IDLE;
        end
      end
      OWNED: begin
        if (!own_cyc_s) begin
          last_d = owner_q;
          if (found_s) begin
            owner_d = pick_s;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = OWNED;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Watchdog: counts stalled strobe cycles of the current owner.
  always_comb begin
    wdog_d = '0;
    if (!owned_s || !own_cyc_s || timeout_hit_s) begin
      wdog_d = '0;
    end else if (own_stb_s && !resp_s) begin
      wdog_d = wdog_q + CW'(1);
    end else begin
      wdog_d = '0;
    end
  end

  // armed_q delays arbitration by one edge after reset release.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= OW'(NM - 1);
      wdog_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      armed_q <= 1'b1;
    end
  end

  // AND-OR mux of the owner's request onto the slave port.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cti_o = 3'b000;
    wbs_bte_o = 2'b00;
    for (int i = 0; i < NM; i++) begin
      wbs_adr_o = wbs_adr_o | ({AW{own_oh_s[i]}} & wbm_adr_i[i*AW +: AW]);
      wbs_dat_o = wbs_dat_o | ({DW{own_oh_s[i]}} & wbm_dat_i[i*DW +: DW]);
      wbs_sel_o = wbs_sel_o | ({SW{own_oh_s[i]}} & wbm_sel_i[i*SW +: SW]);
      wbs_we_o  = wbs_we_o  | (own_oh_s[i] & wbm_we_i[i]);
      wbs_cti_o = wbs_cti_o | ({3{own_oh_s[i]}} & wbm_cti_i[i*3 +: 3]);
      wbs_bte_o = wbs_bte_o | ({2{own_oh_s[i]}} & wbm_bte_i[i*2 +: 2]);
    end
  end

  assign wbs_cyc_o = own_cyc_s;
  assign wbs_stb_o = own_stb_s & ~timeout_hit_s;
  assign wbm_dat_o = wbs_dat_i;
  assign grant_o   = own_oh_s;
  assign wbm_ack_o = own_oh_s & {NM{wbs_ack_i & ~timeout_hit_s}};
  assign wbm_err_o = own_oh_s & {NM{wbs_err_i | timeout_hit_s}};
  assign wbm_rty_o = own_oh_s & {NM{wbs_rty_i & ~timeout_hit_s}};

endmodule

// File: tb/tb_mpsoc_wb_arbiter.sv
// Directed bench for mpsoc_wb_arbiter: a behavioural ownership model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_mpsoc_wb_arbiter;
  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic wb_clk = 1'b0;
  logic wb_rst_n = 1'b1;
  always #5 wb_clk = ~wb_clk;

  logic [AW-1:0] m_adr [NM];
  logic [DW-1:0] m_dat [NM];
  logic [3:0]    m_sel [NM];
  logic [2:0]    m_cti [NM];
  logic [1:0]    m_bte [NM];
  logic [NM-1:0] m_we, m_cyc, m_stb;

  logic [NM*AW-1:0] b_adr;
  logic [NM*DW-1:0] b_dat;
  logic [NM*4-1:0]  b_sel;
  logic [NM*3-1:0]  b_cti;
  logic [NM*2-1:0]  b_bte;

  logic [DW-1:0] s_dat = 32'hCAFE_0000;
  logic auto_ack = 1'b0, ack_force = 1'b0, err_force = 1'b0, rty_force = 1'b0;
  logic s_ack, s_err, s_rty;

  logic [DW-1:0] wbm_dat_o, wbs_adr_o, wbs_dat_o;
  logic [NM-1:0] wbm_ack_o, wbm_err_o, wbm_rty_o, grant_o;
  logic [3:0]    wbs_sel_o;
  logic          wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]    wbs_cti_o;
  logic [1:0]    wbs_bte_o;

  int n_tests = 0;
  int n_fail = 0;

  mpsoc_wb_arbiter #(.DW(DW), .AW(AW), .NM(NM), .TIMEOUT(TO)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .wbm_adr_i(b_adr), .wbm_dat_i(b_dat), .wbm_sel_i(b_sel),
    .wbm_we_i(m_we), .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb),
    .wbm_cti_i(b_cti), .wbm_bte_i(b_bte),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .grant_o(grant_o)
  );

  always_comb begin
    for (int i = 0; i < NM; i++) begin
      b_adr[i*AW +: AW] = m_adr[i];
      b_dat[i*DW +: DW] = m_dat[i];
      b_sel[i*4 +: 4]   = m_sel[i];
      b_cti[i*3 +: 3]   = m_cti[i];
      b_bte[i*2 +: 2]   = m_bte[i];
    end
  end

  always @(posedge wb_clk) s_dat <= s_dat + 32'h0101_0101;

  // Behavioural model: owner index (-1 = nobody), last owner, stall cycles, arbitration enabled.
  int m_owner = -1;
  int m_last = NM - 1;
  int m_stall = 0;
  bit m_ready = 1'b0;

  logic exp_stb, exp_hit;
  assign exp_hit = (m_owner >= 0) && (m_stall == TO);
  assign exp_stb = (m_owner >= 0) ? (m_stb[m_owner] && !exp_hit) : 1'b0;
  assign s_ack = (auto_ack & exp_stb) | ack_force;
  assign s_err = err_force;
  assign s_rty = rty_force;

  always @(posedge wb_clk or negedge wb_rst_n) begin : model_upd
    int n_owner, n_last, n_stall, cand;
    if (!wb_rst_n) begin
      m_owner <= -1;
      m_last  <= NM - 1;
      m_stall <= 0;
      m_ready <= 1'b0;
    end else begin
      n_owner = m_owner;
      n_last  = m_last;
      n_stall = 0;
      if (m_owner >= 0 && m_cyc[m_owner]) begin
        if (m_stall == TO) n_stall = 0;
        else if (m_stb[m_owner] && !(s_ack || s_err || s_rty)) n_stall = m_stall + 1;
        else n_stall = 0;
      end else begin
        if (m_owner >= 0) n_last = m_owner;
        n_owner = -1;
        if (m_ready) begin
          for (int off = 1; off <= NM; off++) begin
            cand = (n_last + off) % NM;
            if (n_owner < 0 && m_cyc[cand]) n_owner = cand;
          end
        end
      end
      m_owner <= n_owner;
      m_last  <= n_last;
      m_stall <= n_stall;
      m_ready <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge wb_clk) begin : cmp
    logic [NM-1:0] eg, ea, ee, er;
    eg = '0; ea = '0; ee = '0; er = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ea[m_owner] = s_ack && !exp_hit;
      ee[m_owner] = s_err || exp_hit;
      er[m_owner] = s_rty && !exp_hit;
    end
    chk("m_grant", grant_o, eg);
    chk("m_ack", wbm_ack_o, ea);
    chk("m_err", wbm_err_o, ee);
    chk("m_rty", wbm_rty_o, er);
    chk("m_rdat", wbm_dat_o, s_dat);
    chk("m_stb", wbs_stb_o, exp_stb);
    chk("m_cyc", wbs_cyc_o, (m_owner >= 0) ? m_cyc[m_owner] : 1'b0);
    chk("m_adr", wbs_adr_o, (m_owner >= 0) ? m_adr[m_owner] : 32'h0);
    chk("m_dat", wbs_dat_o, (m_owner >= 0) ? m_dat[m_owner] : 32'h0);
    chk("m_sel", wbs_sel_o, (m_owner >= 0) ? m_sel[m_owner] : 4'h0);
    chk("m_we", wbs_we_o, (m_owner >= 0) ? m_we[m_owner] : 1'b0);
    chk("m_cti", wbs_cti_o, (m_owner >= 0) ? m_cti[m_owner] : 3'b000);
    chk("m_bte", wbs_bte_o, (m_owner >= 0) ? m_bte[m_owner] : 2'b00);
  end

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic clear_masters();
    m_cyc = '0;
    m_stb = '0;
    for (int i = 0; i < NM; i++) begin
      m_cti[i] = 3'b000;
      m_bte[i] = 2'b00;
    end
  endtask

  task automatic do_reset();
    clear_masters();
    auto_ack = 1'b0; ack_force = 1'b0; err_force = 1'b0; rty_force = 1'b0;
    wb_rst_n = 1'b0;
    tick();
    tick();
    wb_rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    m_we = '0;
    for (int i = 0; i < NM; i++) begin
      m_adr[i] = 32'hA000_0000 | (32'(i) << 8);
      m_dat[i] = 32'h1111_1111 * 32'(i + 1);
      m_sel[i] = 4'(i + 1);
      m_we[i]  = i[0];
    end
    clear_masters();
    #1 wb_rst_n = 1'b0;
    @(negedge wb_clk);
    chk("rst_grant", grant_o, 4'b0000);
    chk("rst_wbs_cyc", wbs_cyc_o, 1'b0);
    tick();
    tick();
    wb_rst_n = 1'b1;
    tick();

    // Single request from master 1
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; auto_ack = 1'b1;
    @(negedge wb_clk);
    chk("r19_grant_c0", grant_o, 4'b0000);
    tick();
    @(negedge wb_clk);
    chk("r19_grant_c1", grant_o, 4'b0010);
    chk("r19_stb_c1", wbs_stb_o, 1'b1);
    chk("r19_ack_c1", wbm_ack_o, 4'b0010);
    tick();
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    tick();
    @(negedge wb_clk);
    chk("r19_grant_idle", grant_o, 4'b0000);

    // Contention from reset: grant order 0,1,2,3 two cycles each
    do_reset();
    m_cyc = 4'b1111; m_stb = 4'b1111; auto_ack = 1'b1;
    begin
      logic [NM-1:0] acked;
      logic [NM-1:0] tbl [9];
      tbl = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0000};
      acked = '0;
      for (int k = 0; k < 9; k++) begin
        tick();
        m_cyc = m_cyc & ~acked;
        m_stb = m_stb & ~acked;
        @(negedge wb_clk);
        chk("r20_grant", grant_o, tbl[k]);
        acked = (m_owner >= 0 && s_ack) ? (4'b0001 << m_owner) : 4'b0000;
      end
    end

    // Burst lock: master 0 4-beat incrementing burst while master 2 waits
    do_reset();
    m_cti[0] = 3'b010; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1; auto_ack = 1'b1;
    for (int b = 1; b <= 6; b++) begin
      tick();
      if (b >= 2 && b <= 4) m_adr[0] = m_adr[0] + 32'd4;
      if (b == 4) m_cti[0] = 3'b111;
      if (b == 5) begin m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_cti[0] = 3'b000; end
      @(negedge wb_clk);
      chk("r21_grant", grant_o, (b <= 5) ? 4'b0001 : 4'b0100);
      if (b == 2) chk("r21_cti", wbs_cti_o, 3'b010);
      if (b <= 5) chk("r21_ack2", wbm_ack_o[2], 1'b0);
    end
    tick();
    m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
    tick();

    // Watchdog: master 3 stalls, slave silent; second hit also ignores a late ack
    m_cyc[3] = 1'b1; m_stb[3] = 1'b1; auto_ack = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      tick();
      ack_force = (k == 34);
      @(negedge wb_clk);
      chk("r22_err", wbm_err_o, (k == 17 || k == 34) ? 4'b1000 : 4'b0000);
      chk("r22_stb", wbs_stb_o, (k == 17 || k == 34) ? 1'b0 : 1'b1);
      chk("r22_ack", wbm_ack_o, 4'b0000);
    end
    tick();
    ack_force = 1'b0; m_cyc[3] = 1'b0; m_stb[3] = 1'b0;
    tick();

    // Error then retry to master 2; final ack lands as cyc drops
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      err_force = (k == 3);
      rty_force = (k == 4);
      ack_force = (k == 5);
      if (k == 5) begin m_cyc[2] = 1'b0; m_stb[2] = 1'b0; end
      @(negedge wb_clk);
      chk("r24_err", wbm_err_o, (k == 3) ? 4'b0100 : 4'b0000);
      chk("r24_rty", wbm_rty_o, (k == 4) ? 4'b0100 : 4'b0000);
      chk("r24_ack", wbm_ack_o, (k == 5) ? 4'b0100 : 4'b0000);
      if (k >= 4) chk("r24_wdog", dut.wdog_q, 5'd0);
    end
    tick();
    ack_force = 1'b0; err_force = 1'b0; rty_force = 1'b0;
    tick();

    // Asynchronous reset in the middle of a burst
    m_cti[0] = 3'b010; m_cyc[0] = 1'b1; m_stb[0] = 1'b1; auto_ack = 1'b1;
    tick();
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    @(negedge wb_clk);
    chk("r23_grant_pre", grant_o, 4'b0001);
    tick();
    #1 wb_rst_n = 1'b0;
    #1;
    chk("r23_grant_async", grant_o, 4'b0000);
    chk("r23_cyc_async", wbs_cyc_o, 1'b0);
    chk("r23_stb_async", wbs_stb_o, 1'b0);
    chk("r23_adr_async", wbs_adr_o, 32'h0);
    tick();
    tick();
    wb_rst_n = 1'b1;
    @(negedge wb_clk);
    chk("r23_grant_rel", grant_o, 4'b0000);
    tick();
    @(negedge wb_clk);
    chk("r23_grant_e1", grant_o, 4'b0000);
    tick();
    @(negedge wb_clk);
    chk("r23_grant_e2", grant_o, 4'b0001);
    tick();
    clear_masters();
    tick();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
